// File: rtl/comp_mem_read_sequencer_if.sv
//-----------------------------------------------------------------------------
// comp_mem_read_sequencer_if
// Bundles the compression-memory read port and the outgoing valid/ready
// stream of the read sequencer. The master side is the sequencer; the slave
// side is the memory plus the stream consumer.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

interface comp_mem_read_sequencer_if #(
    parameter int AHB_WIDTH = 32
);
    // Memory read port: read data is returned combinationally
    logic                 mem_rd_en;
    logic [31:0]          mem_address;
    logic [AHB_WIDTH-1:0] mem_rdata;

    // Output stream
    logic [AHB_WIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output mem_rd_en,
        output mem_address,
        input  mem_rdata,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  mem_rd_en,
        input  mem_address,
        output mem_rdata,
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/comp_mem_read_sequencer.sv
//-----------------------------------------------------------------------------
// comp_mem_read_sequencer
// HCLK-side sequencer that drains a programmed run of words from the
// compression output memory into a valid/ready stream. A run can be gated on
// the image-received event; the memory is read one word per cycle with
// back-pressure from the stream. Completion, error and image-pending status
// are reported to the register block and interrupt logic.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module comp_mem_read_sequencer #(
    parameter int MEM_COMP_DEPTH = 3584,
    parameter int AHB_WIDTH      = 32,
    parameter int CNT_WIDTH      = 12
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,

    // Run command
    input  logic                  start,
    input  logic                  wait_img,
    input  logic [CNT_WIDTH-1:0]  base_addr,
    input  logic [CNT_WIDTH-1:0]  word_count,
    input  logic                  abort,
    input  logic                  img_event,

    // Memory read port and output stream
    comp_mem_read_sequencer_if.master bus,

    // Status
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  img_pending
);

    // Depth held one bit wider than the counters so that a count equal to
    // the full depth still compares correctly.
    localparam logic [CNT_WIDTH:0]   DEPTH_W   = (CNT_WIDTH+1)'(MEM_COMP_DEPTH);
    localparam logic [CNT_WIDTH-1:0] LAST_ADDR = CNT_WIDTH'(MEM_COMP_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_IMG,
        S_READ,
        S_DRAIN
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic [CNT_WIDTH-1:0] addr;
    logic [CNT_WIDTH-1:0] remaining;
    logic [AHB_WIDTH-1:0] out_data_q;
    logic                 out_valid_q;
    logic                 rd_en;

    logic                 params_ok;
    logic                 start_ok;
    logic                 start_bad;
    logic                 rd_fire;
    logic                 img_take;
    logic                 drain_hs;
    logic                 overrun;

    // A run is legal only if it is non-empty, fits in the memory and starts
    // inside it.
    assign params_ok = (word_count != '0)
                    && ({1'b0, word_count} <= DEPTH_W)
                    && ({1'b0, base_addr}  <  DEPTH_W);

    // Abort outranks everything, including a start in the same cycle.
    assign start_ok  = start && !abort && (state == S_IDLE) &&  params_ok;
    assign start_bad = start && !abort && (state == S_IDLE) && !params_ok;

    // A strobe issued in the abort cycle is not captured.
    assign rd_fire   = rd_en && !abort;

    // An image event arriving while waiting is consumed on the spot.
    assign img_take  = (state == S_WAIT_IMG) && !abort && (img_pending || img_event);

    assign drain_hs  = (state == S_DRAIN) && !abort && out_valid_q && bus.out_ready;

    // A second image event before the first was consumed is an overrun.
    assign overrun   = img_event && img_pending;

    // State register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and read strobe; the strobe depends only on the registered
    // state and the stream handshake, never on the command inputs.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    state_nxt = wait_img ? S_WAIT_IMG : S_READ;
                end
            end
            S_WAIT_IMG: begin
                if (img_pending || img_event) begin
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                rd_en = !out_valid_q || bus.out_ready;
                if (rd_en && (remaining == CNT_WIDTH'(1))) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_valid_q && bus.out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (abort) begin
            state_nxt = S_IDLE;
        end
    end

    // Address and remaining-word counters; the address wraps by explicit
    // compare against the memory depth, not at the counter width.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr      <= '0;
            remaining <= '0;
        end else if (start_ok) begin
            addr      <= base_addr;
            remaining <= word_count;
        end else if (rd_fire) begin
            addr      <= (addr == LAST_ADDR) ? '0 : addr + CNT_WIDTH'(1);
            remaining <= remaining - CNT_WIDTH'(1);
        end
    end

    // Output stream register: captures each issued read, holds under stall.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (abort) begin
            out_valid_q <= 1'b0;
        end else if (rd_fire) begin
            out_data_q  <= bus.mem_rdata;
            out_valid_q <= 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Completion pulse, raised for the cycle after the last word is taken.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            done <= 1'b0;
        end else begin
            done <= drain_hs;
        end
    end

    // Sticky error: set by a rejected start or an image overrun, cleared
    // only by an accepted start (a simultaneous set wins).
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            err <= 1'b0;
        end else if (start_bad || overrun) begin
            err <= 1'b1;
        end else if (start_ok) begin
            err <= 1'b0;
        end
    end

    // Image-pending latch: consumption in WAIT_IMG clears it unless a fresh
    // event lands on a flag that was already set.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            img_pending <= 1'b0;
        end else if (img_take) begin
            img_pending <= img_pending && img_event;
        end else if (img_event) begin
            img_pending <= 1'b1;
        end
    end

    assign busy            = (state != S_IDLE);
    assign bus.mem_rd_en   = rd_en;
    assign bus.mem_address = {{(32-CNT_WIDTH){1'b0}}, addr};
    assign bus.out_data    = out_data_q;
    assign bus.out_valid   = out_valid_q;

endmodule
